// File: rtl/line_buffer_row_sequencer.sv
// Row-command sequencer for the input line buffer.
// Walks N rows over C channels, one command per Done_1row.
module line_buffer_row_sequencer #(
  parameter int SIZE_WIDTH = 8,
  parameter int CH_WIDTH   = 9
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [SIZE_WIDTH-1:0] IMAGE_SIZE,
  input  logic [CH_WIDTH-1:0]   CHANNEL_SIZE,
  input  logic                  Done_1row,
  output logic                  Stream_first_row,
  output logic                  Stream_mid_row,
  output logic                  Stream_last_row,
  output logic                  last_channel,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [SIZE_WIDTH-1:0] row_idx,
  output logic [CH_WIDTH-1:0]   ch_idx
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t state;

  logic [SIZE_WIDTH-1:0] n_lat;
  logic [CH_WIDTH-1:0]   c_lat;
  logic [SIZE_WIDTH-1:0] row_last;
  logic [CH_WIDTH-1:0]   ch_last;
  logic [SIZE_WIDTH-1:0] row_nxt;
  logic [CH_WIDTH-1:0]   ch_nxt;
  logic                  cfg_bad;

  assign row_last = n_lat - SIZE_WIDTH'(1);
  assign ch_last  = c_lat - CH_WIDTH'(1);
  assign row_nxt  = row_idx + SIZE_WIDTH'(1);
  assign ch_nxt   = ch_idx + CH_WIDTH'(1);
  assign cfg_bad  = (IMAGE_SIZE < SIZE_WIDTH'(2)) ||
                    (CHANNEL_SIZE == '0);

  // Command pulses are registered on entry to ISSUE.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state            <= IDLE;
      n_lat            <= '0;
      c_lat            <= '0;
      row_idx          <= '0;
      ch_idx           <= '0;
      Stream_first_row <= 1'b0;
      Stream_mid_row   <= 1'b0;
      Stream_last_row  <= 1'b0;
      last_channel     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_err          <= 1'b0;
    end else begin
      Stream_first_row <= 1'b0;
      Stream_mid_row   <= 1'b0;
      Stream_last_row  <= 1'b0;
      done             <= 1'b0;
      cfg_err          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              n_lat            <= IMAGE_SIZE;
              c_lat            <= CHANNEL_SIZE;
              row_idx          <= '0;
              ch_idx           <= '0;
              busy             <= 1'b1;
              Stream_first_row <= 1'b1;
              last_channel     <= (CHANNEL_SIZE == CH_WIDTH'(1));
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (Done_1row) begin
            if (row_idx != row_last) begin
              row_idx <= row_nxt;
              state   <= ISSUE;
              if (row_nxt == row_last) begin
                Stream_last_row <= 1'b1;
              end else begin
                Stream_mid_row <= 1'b1;
              end
            end else if (ch_idx != ch_last) begin
              row_idx          <= '0;
              ch_idx           <= ch_nxt;
              Stream_first_row <= 1'b1;
              last_channel     <= (ch_nxt == ch_last);
              state            <= ISSUE;
            end else begin
              done         <= 1'b1;
              busy         <= 1'b0;
              last_channel <= 1'b0;
              state        <= FINISH;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
